load_store_unit: RTL and testbench
==================================

# load_store_unit

Pipeline-side memory access controller driving the single-ported data memory (32 words × 32 bits, combinational read when `read` is high, write on rising `clk` when `write` is high). It accepts one load/store request at a time from the MEM stage over a valid/ready handshake. It translates byte addresses and byte/half/word sizes into word accesses, and performs read-modify-write for sub-word stores. Results, including sign/zero-extended load data and an alignment error flag, are returned on a valid/ready response channel.

## Interface
- `REGSIZE`, 32: data width; fixed at 32 because the byte-lane logic assumes 4 lanes.
- `ADDRBITS`, 5: word address width; the byte address is `ADDRBITS+2` bits.
- `clk` in 1: clock; all state changes on the rising edge.
- `reset` in 1: synchronous, active-high.
- `req_valid` in 1: request present.
- `req_ready` out 1: unit can accept; high only in IDLE.
- `req_write` in 1: 1 = store, 0 = load.
- `req_size` in 2: 00 byte, 01 half, 10 word, 11 reserved.
- `req_signed` in 1: sign-extend a sub-word load.
- `req_addr` in ADDRBITS+2: byte address.
- `req_wdata` in REGSIZE: store data, right-aligned.
- `resp_valid` out 1: response present.
- `resp_ready` in 1: consumer takes the response.
- `resp_data` out REGSIZE: load result; 0 for stores and errors.
- `resp_error` out 1: misaligned or reserved-size request.
- `mem_read` out 1: memory read strobe.
- `mem_write` out 1: memory write strobe.
- `mem_addr` out ADDRBITS: word address, equal to `req_addr[ADDRBITS+1:2]`.
- `mem_wdata` out REGSIZE: full word to write.
- `mem_rdata` in REGSIZE: combinational memory read data.

## Operation
- States: IDLE, ACCESS, MERGE, RESP.
- IDLE: `req_ready`=1. On `req_valid`, latch all request fields.
  - Misaligned requests go straight to RESP with error=1. Misaligned means half with addr[0]=1, word with addr[1:0]≠0, or size 11.
  - Otherwise go to ACCESS.
- ACCESS, load: `mem_read`=1. At the clock edge, extract the lane selected by addr[1:0] (byte) or addr[1] (half), then extend it: sign-extend if `req_signed`, else zero-extend. Register the result into `resp_data` and go to RESP.
- ACCESS, word store: `mem_write`=1, `mem_wdata`=latched wdata. Go to RESP.
- ACCESS, sub-word store: `mem_read`=1. Capture `mem_rdata` into the merge register and go to MERGE.
- MERGE: `mem_write`=1. `mem_wdata` is the captured word with the target lane(s) replaced by wdata[7:0] or wdata[15:0]. Go to RESP.
- RESP: `resp_valid`=1, and `resp_data` and `resp_error` are held stable. Return to IDLE on `resp_ready`; otherwise stay.
- Byte order is little-endian: byte 0 is bits 7:0, half 0 is bits 15:0.
- `mem_read` and `mem_write` are never high together. Both are decoded from state only, never from request inputs directly.
- `mem_addr` is driven from the latched address in every state; in IDLE it is 0.

## Timing
- Reset values: state IDLE, `req_ready`=1, `resp_valid`=0, `resp_data`=0, `resp_error`=0, `mem_read`=0, `mem_write`=0, `mem_addr`=0, `mem_wdata`=0.
- Cycle 0 is the edge where the request is accepted.
  - Load or word store: `resp_valid` rises 2 edges later.
  - Sub-word store: `resp_valid` rises 3 edges later.
  - Error: `resp_valid` rises 1 edge later.
- A word-store write lands at the edge ending ACCESS; a sub-word store write lands at the edge ending MERGE.
- Throughput: at most one request in flight. Because `req_ready`=0 outside IDLE, no request is accepted in the same cycle a response completes; the next acceptance is at the earliest 1 cycle after `resp_ready`.
- Response backpressure: `resp_valid` and its data stay unchanged for any number of cycles until `resp_ready`.
- Reset mid-operation: reset wins over every state transition, and all registers return to their reset values.
  - If reset is asserted during a cycle where `mem_write`=1, that write still lands at that edge, because the memory is not reset.
  - Reset asserted during ACCESS/read of a sub-word store produces no write.
- `req_*` inputs are ignored outside IDLE.

## Test plan
- Word store then load: store 0xDEADBEEF at addr 0x08, then load word at 0x08. Required: the write lands on word 2, and the load returns 0xDEADBEEF, error 0, with 2-cycle latency each.
- Byte store read-modify-write: preload word 3 with 0x11223344, store byte 0xAB at addr 0x0D. Required: exactly one read cycle, then one write cycle with `mem_wdata`=0x1122AB44; a later word load at 0x0C returns 0x1122AB44.
- Signed/unsigned sub-word loads: word 5 = 0x80F07F01.
  - lb at 0x16 → 0xFFFFFFF0; lbu at 0x16 → 0x000000F0.
  - lh at 0x16 → 0xFFFF80F0; lhu at 0x14 → 0x00007F01.
- Misaligned and reserved requests: lh at 0x03, lw at 0x06, and size 11 at 0x00. Required: `resp_error`=1, `resp_data`=0, response after 1 edge, and `mem_read`/`mem_write` never asserted.
- Backpressure: hold `resp_ready`=0 for 5 cycles after a load. Required: `resp_valid` and `resp_data` remain stable, `req_ready`=0, and a new `req_valid` is not accepted until 1 cycle after `resp_ready`=1.
- Reset mid-operation: assert reset during ACCESS of a half store to 0x10. Required: no memory write, all outputs return to reset values next cycle, and word 4 is unchanged.

Source files
------------

// File: rtl/load_store_unit.sv
// load_store_unit: MEM-stage front end for the single-ported 32x32 data memory.
// Accepts one byte/half/word load or store at a time, turns byte addresses
// into word accesses, merges sub-word stores through a read-modify-write and
// returns extended load data plus an alignment error on a response channel.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | ready for a request; latches it and checks alignment
// ACCESS | memory access: load read, word-store write, or sub-word read
// MERGE  | sub-word store: write captured word with target lane replaced
// RESP   | response held stable until the consumer takes it
module load_store_unit #(
  parameter int REGSIZE  = 32,
  parameter int ADDRBITS = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic [ADDRBITS+1:0]   req_addr,
  input  logic [REGSIZE-1:0]    req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [REGSIZE-1:0]    resp_data,
  output logic                  resp_error,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDRBITS-1:0]   mem_addr,
  output logic [REGSIZE-1:0]    mem_wdata,
  input  logic [REGSIZE-1:0]    mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, MERGE, RESP} state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  state_t state, state_nxt;

  logic                 write_q;
  logic [1:0]           size_q;
  logic                 signed_q;
  logic [ADDRBITS+1:0]  addr_q;
  logic [REGSIZE-1:0]   wdata_q;
  logic [REGSIZE-1:0]   merge_q;
  logic [REGSIZE-1:0]   resp_data_q;
  logic                 resp_error_q;

  logic                 req_misaligned;
  logic                 sub_word;
  logic [7:0]           lane8;
  logic [15:0]          lane16;
  logic [REGSIZE-1:0]   load_ext;
  logic [REGSIZE-1:0]   merged;

  // Alignment / reserved-size check on the incoming request
  always_comb begin
    req_misaligned = 1'b0;
    case (req_size)
      SZ_HALF: req_misaligned = req_addr[0];
      SZ_WORD: req_misaligned = (req_addr[1:0] != 2'b00);
      SZ_RSVD: req_misaligned = 1'b1;
      default: req_misaligned = 1'b0;
    endcase
  end

  assign sub_word = (size_q != SZ_WORD);

  // Lane extraction and sign/zero extension of the memory read word
  always_comb begin
    lane8    = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
    lane16   = mem_rdata[{addr_q[1], 4'b0000} +: 16];
    load_ext = mem_rdata;
    case (size_q)
      SZ_BYTE: load_ext = {{(REGSIZE-8){signed_q & lane8[7]}}, lane8};
      SZ_HALF: load_ext = {{(REGSIZE-16){signed_q & lane16[15]}}, lane16};
      default: load_ext = mem_rdata;
    endcase
  end

  // Replace the addressed lane(s) of the captured word with store data
  always_comb begin
    merged = merge_q;
    case (size_q)
      SZ_BYTE: merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      SZ_HALF: merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      default: merged = merge_q;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req_valid) state_nxt = req_misaligned ? RESP : ACCESS;
      end
      ACCESS: begin
        if (write_q && sub_word) state_nxt = MERGE;
        else                     state_nxt = RESP;
      end
      MERGE: state_nxt = RESP;
      RESP: begin
        if (resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode, from state and latched request only
  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    case (state)
      IDLE: req_ready = 1'b1;
      ACCESS: begin
        mem_addr = addr_q[ADDRBITS+1:2];
        if (write_q && !sub_word) begin
          mem_write = 1'b1;
          mem_wdata = wdata_q;
        end else begin
          mem_read = 1'b1;
        end
      end
      MERGE: begin
        mem_addr  = addr_q[ADDRBITS+1:2];
        mem_write = 1'b1;
        mem_wdata = merged;
      end
      RESP: begin
        mem_addr   = addr_q[ADDRBITS+1:2];
        resp_valid = 1'b1;
      end
      default: ;
    endcase
  end

  // Request latch, merge capture and response registers
  always_ff @(posedge clk) begin
    if (reset) begin
      write_q      <= 1'b0;
      size_q       <= SZ_BYTE;
      signed_q     <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      merge_q      <= '0;
      resp_data_q  <= '0;
      resp_error_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            write_q      <= req_write;
            size_q       <= req_size;
            signed_q     <= req_signed;
            addr_q       <= req_addr;
            wdata_q      <= req_wdata;
            resp_data_q  <= '0;
            resp_error_q <= req_misaligned;
          end
        end
        ACCESS: begin
          if (!write_q)     resp_data_q <= load_ext;
          else if (sub_word) merge_q    <= mem_rdata;
        end
        default: ;
      endcase
    end
  end

  assign resp_data  = resp_data_q;
  assign resp_error = resp_error_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed tests for load_store_unit with a behavioural
// 32x32 memory model and hand-computed expected values.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [6:0]  req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic        resp_error;
  logic        mem_read;
  logic        mem_write;
  logic [4:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] mem [32];
  int          wr_cnt = 0;
  int          rd_cnt = 0;
  logic [31:0] last_wdata = '0;
  logic [4:0]  last_waddr = '0;

  int n_vec = 0;
  int n_bad = 0;

  load_store_unit #(.REGSIZE(32), .ADDRBITS(5)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_error(resp_error),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem_read ? mem[mem_addr] : 32'h0;

  always @(posedge clk) begin
    if (mem_write) begin
      mem[mem_addr] <= mem_wdata;
      wr_cnt        <= wr_cnt + 1;
      last_wdata    <= mem_wdata;
      last_waddr    <= mem_addr;
    end
    if (mem_read) rd_cnt <= rd_cnt + 1;
  end

  // Issue one request from a negedge, wait (bounded) for the response, take it.
  // lat counts edges from the accepting edge inclusive to resp_valid.
  task automatic run_req(input logic w, input logic [1:0] sz, input logic sg,
                         input logic [6:0] a, input logic [31:0] wd,
                         output int lat, output logic [31:0] data, output logic err);
    req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wd;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 10) begin
      n_vec++;
      if (mem_read && mem_write) begin
        n_bad++; $display("FAIL rd_wr_exclusive: read=%0b write=%0b required not both", mem_read, mem_write);
      end
      @(posedge clk); @(negedge clk);
      lat++;
    end
    data = resp_data;
    err  = resp_error;
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_vec++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL rst_req_ready: got %b required 1", req_ready); end
    n_vec++; if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL rst_resp_valid: got %b required 0", resp_valid); end
    n_vec++; if (resp_data !== 32'h0) begin n_bad++; $display("FAIL rst_resp_data: got %h required 0", resp_data); end
    n_vec++; if (resp_error !== 1'b0) begin n_bad++; $display("FAIL rst_resp_error: got %b required 0", resp_error); end
    n_vec++; if (mem_read !== 1'b0) begin n_bad++; $display("FAIL rst_mem_read: got %b required 0", mem_read); end
    n_vec++; if (mem_write !== 1'b0) begin n_bad++; $display("FAIL rst_mem_write: got %b required 0", mem_write); end
    n_vec++; if (mem_addr !== 5'h0) begin n_bad++; $display("FAIL rst_mem_addr: got %h required 0", mem_addr); end
    n_vec++; if (mem_wdata !== 32'h0) begin n_bad++; $display("FAIL rst_mem_wdata: got %h required 0", mem_wdata); end
    reset = 1'b0;
  endtask

  task automatic test_word_store_load();
    int lat; logic [31:0] d; logic e; int w0;
    w0 = wr_cnt;
    run_req(1'b1, 2'b10, 1'b0, 7'h08, 32'hDEADBEEF, lat, d, e);
    n_vec++; if (lat !== 2) begin n_bad++; $display("FAIL sw_latency: got %0d required 2", lat); end
    n_vec++; if (e !== 1'b0) begin n_bad++; $display("FAIL sw_error: got %b required 0", e); end
    n_vec++; if (d !== 32'h0) begin n_bad++; $display("FAIL sw_data: got %h required 0", d); end
    n_vec++; if (wr_cnt - w0 !== 1) begin n_bad++; $display("FAIL sw_write_count: got %0d required 1", wr_cnt - w0); end
    n_vec++; if (last_waddr !== 5'd2) begin n_bad++; $display("FAIL sw_waddr: got %0d required 2", last_waddr); end
    n_vec++; if (mem[2] !== 32'hDEADBEEF) begin n_bad++; $display("FAIL sw_mem2: got %h required deadbeef", mem[2]); end
    run_req(1'b0, 2'b10, 1'b0, 7'h08, 32'h0, lat, d, e);
    n_vec++; if (lat !== 2) begin n_bad++; $display("FAIL lw_latency: got %0d required 2", lat); end
    n_vec++; if (d !== 32'hDEADBEEF) begin n_bad++; $display("FAIL lw_data: got %h required deadbeef", d); end
    n_vec++; if (e !== 1'b0) begin n_bad++; $display("FAIL lw_error: got %b required 0", e); end
  endtask

  task automatic test_byte_rmw();
    int lat; logic [31:0] d; logic e; int w0, r0;
    run_req(1'b1, 2'b10, 1'b0, 7'h0C, 32'h11223344, lat, d, e);
    w0 = wr_cnt; r0 = rd_cnt;
    run_req(1'b1, 2'b00, 1'b0, 7'h0D, 32'h55AA00AB, lat, d, e);
    n_vec++; if (lat !== 3) begin n_bad++; $display("FAIL sb_latency: got %0d required 3", lat); end
    n_vec++; if (rd_cnt - r0 !== 1) begin n_bad++; $display("FAIL sb_read_count: got %0d required 1", rd_cnt - r0); end
    n_vec++; if (wr_cnt - w0 !== 1) begin n_bad++; $display("FAIL sb_write_count: got %0d required 1", wr_cnt - w0); end
    n_vec++; if (last_wdata !== 32'h1122AB44) begin n_bad++; $display("FAIL sb_wdata: got %h required 1122ab44", last_wdata); end
    n_vec++; if (e !== 1'b0) begin n_bad++; $display("FAIL sb_error: got %b required 0", e); end
    run_req(1'b0, 2'b10, 1'b0, 7'h0C, 32'h0, lat, d, e);
    n_vec++; if (d !== 32'h1122AB44) begin n_bad++; $display("FAIL sb_readback: got %h required 1122ab44", d); end
  endtask

  task automatic test_subword_loads();
    int lat; logic [31:0] d; logic e;
    logic        sz_w [7];
    logic [1:0]  sz   [7];
    logic        sg   [7];
    logic [6:0]  ad   [7];
    logic [31:0] exp_d[7];
    sz[0] = 2'b00; sg[0] = 1'b1; ad[0] = 7'h16; exp_d[0] = 32'hFFFFFFF0;
    sz[1] = 2'b00; sg[1] = 1'b0; ad[1] = 7'h16; exp_d[1] = 32'h000000F0;
    sz[2] = 2'b01; sg[2] = 1'b1; ad[2] = 7'h16; exp_d[2] = 32'hFFFF80F0;
    sz[3] = 2'b01; sg[3] = 1'b0; ad[3] = 7'h14; exp_d[3] = 32'h00007F01;
    sz[4] = 2'b00; sg[4] = 1'b1; ad[4] = 7'h14; exp_d[4] = 32'h00000001;
    sz[5] = 2'b00; sg[5] = 1'b1; ad[5] = 7'h17; exp_d[5] = 32'hFFFFFF80;
    sz[6] = 2'b01; sg[6] = 1'b1; ad[6] = 7'h14; exp_d[6] = 32'h00007F01;
    for (int i = 0; i < 7; i++) sz_w[i] = 1'b0;
    run_req(1'b1, 2'b10, 1'b0, 7'h14, 32'h80F07F01, lat, d, e);
    for (int i = 0; i < 7; i++) begin
      run_req(sz_w[i], sz[i], sg[i], ad[i], 32'h0, lat, d, e);
      n_vec++; if (d !== exp_d[i]) begin n_bad++; $display("FAIL subload_%0d_data: got %h required %h", i, d, exp_d[i]); end
      n_vec++; if (lat !== 2) begin n_bad++; $display("FAIL subload_%0d_latency: got %0d required 2", i, lat); end
    end
    run_req(1'b1, 2'b01, 1'b0, 7'h16, 32'h0000BEEF, lat, d, e);
    n_vec++; if (mem[5] !== 32'hBEEF7F01) begin n_bad++; $display("FAIL sh_merge: got %h required beef7f01", mem[5]); end
    n_vec++; if (lat !== 3) begin n_bad++; $display("FAIL sh_latency: got %0d required 3", lat); end
  endtask

  task automatic test_misaligned();
    int lat; logic [31:0] d; logic e; int w0, r0;
    logic        wr [4];
    logic [1:0]  sz [4];
    logic [6:0]  ad [4];
    wr[0] = 1'b0; sz[0] = 2'b01; ad[0] = 7'h03;
    wr[1] = 1'b0; sz[1] = 2'b10; ad[1] = 7'h06;
    wr[2] = 1'b0; sz[2] = 2'b11; ad[2] = 7'h00;
    wr[3] = 1'b1; sz[3] = 2'b01; ad[3] = 7'h09;
    for (int i = 0; i < 4; i++) begin
      w0 = wr_cnt; r0 = rd_cnt;
      run_req(wr[i], sz[i], 1'b1, ad[i], 32'hFFFFFFFF, lat, d, e);
      n_vec++; if (e !== 1'b1) begin n_bad++; $display("FAIL mis_%0d_error: got %b required 1", i, e); end
      n_vec++; if (d !== 32'h0) begin n_bad++; $display("FAIL mis_%0d_data: got %h required 0", i, d); end
      n_vec++; if (lat !== 1) begin n_bad++; $display("FAIL mis_%0d_latency: got %0d required 1", i, lat); end
      n_vec++; if ((rd_cnt - r0) + (wr_cnt - w0) !== 0) begin n_bad++; $display("FAIL mis_%0d_mem_access: got %0d required 0", i, (rd_cnt - r0) + (wr_cnt - w0)); end
    end
  endtask

  task automatic test_backpressure();
    int lat;
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_signed = 1'b0;
    req_addr = 7'h08; req_wdata = 32'h0;
    @(posedge clk); @(negedge clk);
    req_addr = 7'h0C;
    lat = 1;
    while (!resp_valid && lat < 10) begin @(posedge clk); @(negedge clk); lat++; end
    n_vec++; if (lat !== 2) begin n_bad++; $display("FAIL bp_latency: got %0d required 2", lat); end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); @(negedge clk);
      n_vec++; if (resp_valid !== 1'b1) begin n_bad++; $display("FAIL bp_hold_%0d_valid: got %b required 1", i, resp_valid); end
      n_vec++; if (resp_data !== 32'hDEADBEEF) begin n_bad++; $display("FAIL bp_hold_%0d_data: got %h required deadbeef", i, resp_data); end
      n_vec++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL bp_hold_%0d_req_ready: got %b required 0", i, req_ready); end
    end
    resp_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    resp_ready = 1'b0;
    n_vec++; if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL bp_release_valid: got %b required 0", resp_valid); end
    n_vec++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL bp_not_accepted_early: req_ready got %b required 1", req_ready); end
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0;
    n_vec++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL bp_accept_next: req_ready got %b required 0", req_ready); end
    lat = 1;
    while (!resp_valid && lat < 10) begin @(posedge clk); @(negedge clk); lat++; end
    n_vec++; if (resp_data !== 32'h1122AB44) begin n_bad++; $display("FAIL bp_second_data: got %h required 1122ab44", resp_data); end
    resp_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    resp_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    int lat; logic [31:0] d; logic e; int w0;
    run_req(1'b1, 2'b10, 1'b0, 7'h10, 32'hCAFEF00D, lat, d, e);
    w0 = wr_cnt;
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b01; req_signed = 1'b0;
    req_addr = 7'h10; req_wdata = 32'h00001234;
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0;
    n_vec++; if (mem_read !== 1'b1) begin n_bad++; $display("FAIL rm_in_access: mem_read got %b required 1", mem_read); end
    reset = 1'b1;
    @(posedge clk); @(negedge clk);
    reset = 1'b0;
    n_vec++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL rm_req_ready: got %b required 1", req_ready); end
    n_vec++; if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL rm_resp_valid: got %b required 0", resp_valid); end
    n_vec++; if (mem_read !== 1'b0 || mem_write !== 1'b0) begin n_bad++; $display("FAIL rm_mem_strobes: got rd=%b wr=%b required 0 0", mem_read, mem_write); end
    n_vec++; if (mem_addr !== 5'h0 || mem_wdata !== 32'h0) begin n_bad++; $display("FAIL rm_mem_bus: got addr=%h wdata=%h required 0 0", mem_addr, mem_wdata); end
    n_vec++; if (resp_data !== 32'h0 || resp_error !== 1'b0) begin n_bad++; $display("FAIL rm_resp_regs: got data=%h err=%b required 0 0", resp_data, resp_error); end
    @(posedge clk); @(negedge clk);
    n_vec++; if (wr_cnt - w0 !== 0) begin n_bad++; $display("FAIL rm_no_write: got %0d writes required 0", wr_cnt - w0); end
    n_vec++; if (mem[4] !== 32'hCAFEF00D) begin n_bad++; $display("FAIL rm_word4: got %h required cafef00d", mem[4]); end
    run_req(1'b0, 2'b10, 1'b0, 7'h10, 32'h0, lat, d, e);
    n_vec++; if (d !== 32'hCAFEF00D) begin n_bad++; $display("FAIL rm_readback: got %h required cafef00d", d); end
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
    req_signed = 1'b0; req_addr = 7'h0; req_wdata = 32'h0; resp_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_word_store_load();
    test_byte_rmw();
    test_subword_loads();
    test_misaligned();
    test_backpressure();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
